// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parking_pkg
// Description : Shared types and widths for the parking gate controller.
//               Defines the controller state encoding, the space/units/fee
//               widths, and a lowest-free-space helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

    localparam int SPACE_W    = 2;
    localparam int UNIT_W     = 8;
    localparam int FEE_W      = 16;
    localparam int MAX_SPACES = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IN = 2'd1,
        BILL     = 2'd2,
        GATE     = 2'd3
    } state_t;

    // Lowest-index clear bit; returns 0 when the map is full (callers gate on
    // full before using the result).
    function automatic logic [SPACE_W-1:0] lowest_free(input logic [MAX_SPACES-1:0] occ);
        lowest_free = '0;
        for (int i = MAX_SPACES - 1; i >= 0; i--) begin
            if (!occ[i]) lowest_free = SPACE_W'(i);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/parking_space_timer.sv
`default_nettype none
// ============================================================================
// Module      : parking_space_timer
// Description : Per-space parked-time counter in billing units. Counts one
//               unit per tick while the space is occupied, saturates at the
//               counter maximum; clear has priority over a coincident tick.
// Ports       : clk, rst (async, active-high), tick (billing-unit strobe),
//               occupied (space in use), clear (restart from zero),
//               units (current parked time)
// Revision    : 1.0 - initial release
// ============================================================================
module parking_space_timer
    import parking_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              occupied,
    input  logic              clear,
    output logic [UNIT_W-1:0] units
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            units <= '0;
        end else if (clear) begin
            units <= '0;
        end else if (tick && occupied && (units != '1)) begin
            units <= units + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_ctrl
// Description : Shared entry/exit barrier controller for a 4-space car park.
//               Round-robin arbitration of entry/exit, lowest-free space
//               allocation, per-space billing timers, fee presentation and
//               barrier sequencing.
// Ports       : clk, rst (async, active-high)
//               entry_req, exit_req, exit_space, paid        - lane inputs
//               entry_ack, assigned_space                    - entry result
//               exit_ack, exit_err                           - exit result
//               fee_valid, fee                               - billing
//               occupied, full                               - occupancy map
//               barrier_open                                 - actuator drive
// Options     : PARKING_PAY_TIMEOUT_EN - abandon BILL after PAY_TIMEOUT
//               cycles without payment (space stays occupied).
// Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int NUM_SPACES  = 4,
    parameter int RATE        = 10,
    parameter int TICK_DIV    = 8,
    parameter int GATE_CYCLES = 3,
    parameter int PAY_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  entry_req,
    input  logic                  exit_req,
    input  logic [SPACE_W-1:0]    exit_space,
    input  logic                  paid,
    output logic                  entry_ack,
    output logic [SPACE_W-1:0]    assigned_space,
    output logic                  exit_ack,
    output logic                  exit_err,
    output logic                  fee_valid,
    output logic [FEE_W-1:0]      fee,
    output logic [NUM_SPACES-1:0] occupied,
    output logic                  full,
    output logic                  barrier_open
);

    localparam logic [15:0]      c_presc_last = 16'(TICK_DIV - 1);
    localparam logic [15:0]      c_gate_last  = 16'(GATE_CYCLES);
    localparam logic [FEE_W-1:0] c_rate       = FEE_W'(RATE);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [15:0]           r_presc;
    logic [15:0]           r_gate_cnt;
    logic                  r_last_exit;   // 1: last grant went to the exit lane
    logic [SPACE_W-1:0]    r_bill_space;
    logic [UNIT_W-1:0]     w_units [NUM_SPACES];
    logic [NUM_SPACES-1:0] w_clear;
    logic [SPACE_W-1:0]    w_free_space;
    logic                  w_tick;
    logic                  w_entry_ok;
    logic                  w_grant_entry;
    logic                  w_grant_exit;
    logic                  w_exit_occ;
    logic                  w_exit_reject;
    logic                  w_exit_bill;
    logic                  w_pay_done;
    logic                  w_timeout;
    logic                  w_gate_done;
    logic                  w_entry_ack_d;
    logic                  w_exit_ack_d;
    logic                  w_exit_err_d;
    logic                  w_fee_valid_d;
    logic                  w_barrier_d;

    assign full         = &occupied;
    assign w_tick       = (r_presc == c_presc_last);
    assign w_free_space = lowest_free(occupied);
    assign w_exit_occ   = occupied[exit_space];

    // Arbitration: only IDLE samples requests. With both lanes eligible the
    // lane that did not win last time is served.
    always_comb begin
        w_entry_ok    = entry_req && !full;
        w_grant_exit  = 1'b0;
        w_grant_entry = 1'b0;
        if (r_state == IDLE) begin
            w_grant_exit  = exit_req && (!w_entry_ok || !r_last_exit);
            w_grant_entry = w_entry_ok && !w_grant_exit;
        end
    end

    assign w_exit_reject = w_grant_exit && !w_exit_occ;
    assign w_exit_bill   = w_grant_exit && w_exit_occ;
    assign w_pay_done    = (r_state == BILL) && paid;
    assign w_gate_done   = (r_state == GATE) && (r_gate_cnt == c_gate_last);

`ifdef PARKING_PAY_TIMEOUT_EN
    logic [15:0] r_pay_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pay_cnt <= '0;
        end else if (r_state != BILL) begin
            r_pay_cnt <= '0;
        end else begin
            r_pay_cnt <= r_pay_cnt + 16'd1;
        end
    end

    // Payment on the final allowed cycle still wins over the timeout.
    assign w_timeout = (r_state == BILL) && !paid && (r_pay_cnt == 16'(PAY_TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_entry)    w_state_nxt = GRANT_IN;
                else if (w_exit_bill) w_state_nxt = BILL;
            end
            GRANT_IN: w_state_nxt = GATE;
            BILL: begin
                if (w_pay_done)     w_state_nxt = GATE;
                else if (w_timeout) w_state_nxt = IDLE;
            end
            GATE: begin
                if (w_gate_done) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered handshake/actuator outputs
    always_comb begin
        w_entry_ack_d = w_grant_entry;
        w_exit_ack_d  = w_exit_reject || w_pay_done || w_timeout;
        w_exit_err_d  = w_exit_reject || w_timeout;
        w_fee_valid_d = (w_state_nxt == BILL);
        // One lag cycle after entering GATE, then GATE_CYCLES cycles open.
        w_barrier_d   = (r_state == GATE) && !w_gate_done;
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_ack      <= 1'b0;
            exit_ack       <= 1'b0;
            exit_err       <= 1'b0;
            fee_valid      <= 1'b0;
            barrier_open   <= 1'b0;
            assigned_space <= '0;
            fee            <= '0;
            occupied       <= '0;
            r_presc        <= '0;
            r_gate_cnt     <= '0;
            r_last_exit    <= 1'b0;
            r_bill_space   <= '0;
        end else begin
            entry_ack    <= w_entry_ack_d;
            exit_ack     <= w_exit_ack_d;
            exit_err     <= w_exit_err_d;
            fee_valid    <= w_fee_valid_d;
            barrier_open <= w_barrier_d;
            r_presc      <= w_tick ? '0 : r_presc + 16'd1;
            r_gate_cnt   <= ((r_state == GATE) && !w_gate_done) ? r_gate_cnt + 16'd1 : '0;

            if (w_grant_entry) begin
                assigned_space         <= w_free_space;
                occupied[w_free_space] <= 1'b1;
                r_last_exit            <= 1'b0;
            end
            if (w_grant_exit) begin
                r_last_exit <= 1'b1;
            end
            // Fee is frozen at BILL entry; the timer keeps running meanwhile.
            if (w_exit_bill) begin
                fee          <= FEE_W'(w_units[exit_space]) * c_rate;
                r_bill_space <= exit_space;
            end
            if (w_pay_done) begin
                occupied[r_bill_space] <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_SPACES; i++) begin : g_space
        assign w_clear[i] = (w_grant_entry && (w_free_space == SPACE_W'(i)))
                         || (w_pay_done && (r_bill_space == SPACE_W'(i)));

        parking_space_timer u_timer (
            .clk      (clk),
            .rst      (rst),
            .tick     (w_tick),
            .occupied (occupied[i]),
            .clear    (w_clear[i]),
            .units    (w_units[i])
        );
    end

endmodule
`default_nettype wire
